// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: Wishbone slave with eight 8-bit registers in an 8-byte window at BASE.
//   R0..R5 read/write storage, R6 read-only count of ack'd accesses, R7 control
//   (bits[1:0] = wait states applied to later ack'd transfers).
//   A write to R7 opens a retry window of HOLDOFF cycles during which requests get rty.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   adr, din, we    address / write data / write enable from master
//   cyc, stb        bus cycle and strobe; request = cyc & stb
//   dout            read data, valid only while ack is high for a read (else 8'h00)
//   ack, err, rty   registered one-cycle terminations, mutually exclusive
module wb_slave_regfile #(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [1:0]    wcnt;
  logic [2:0]    cap_sel;
  logic          cap_we;
  logic [7:0]    cap_din;
  logic [7:0]    regs [0:5];
  logic [7:0]    acc_cnt;
  logic [1:0]    wait_cfg;
  logic [HW-1:0] holdoff;

  logic       req_c;
  logic       bad_c;
  logic       commit_c;
  logic [2:0] csel_c;
  logic       cwe_c;
  logic [7:0] cdin_c;
  logic [7:0] rdata_c;

  assign req_c = cyc & stb;
  // Miss, or write to the read-only counter.
  assign bad_c = (adr[31:3] != BASE[31:3]) || (we && (adr[2:0] == 3'd6));

  // Commit point: zero-wait ack straight from IDLE, or last WAIT edge using captured request.
  always_comb begin
    commit_c = 1'b0;
    csel_c   = adr[2:0];
    cwe_c    = we;
    cdin_c   = din;
    if (state == IDLE) begin
      commit_c = req_c && (holdoff == '0) && !bad_c && (wait_cfg == 2'd0);
    end else if (state == WAIT) begin
      commit_c = req_c && (wcnt == 2'd0);
      csel_c   = cap_sel;
      cwe_c    = cap_we;
      cdin_c   = cap_din;
    end
  end

  // Read mux; R6 returns the pre-increment count.
  always_comb begin
    rdata_c = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (csel_c == 3'(i)) rdata_c = regs[i];
    end
    if (csel_c == 3'd6) rdata_c = acc_cnt;
    if (csel_c == 3'd7) rdata_c = {6'b0, wait_cfg};
  end

  // FSM, terminations, register file and holdoff timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= 2'd0;
      cap_sel  <= 3'd0;
      cap_we   <= 1'b0;
      cap_din  <= 8'h00;
      acc_cnt  <= 8'h00;
      wait_cfg <= 2'd0;
      holdoff  <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rty      <= 1'b0;
      dout     <= 8'h00;
      for (int i = 0; i < 6; i++) regs[i] <= 8'h00;
    end else begin
      ack  <= 1'b0;
      err  <= 1'b0;
      rty  <= 1'b0;
      dout <= 8'h00;
      if (holdoff != '0) holdoff <= holdoff - HW'(1);

      case (state)
        IDLE: begin
          if (req_c) begin
            if (holdoff != '0) begin
              rty   <= 1'b1;
              state <= RESP;
            end else if (bad_c) begin
              err   <= 1'b1;
              state <= RESP;
            end else if (wait_cfg == 2'd0) begin
              state <= RESP;
            end else begin
              cap_sel <= adr[2:0];
              cap_we  <= we;
              cap_din <= din;
              wcnt    <= wait_cfg - 2'd1;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_c)              state <= IDLE;
          else if (wcnt == 2'd0)   state <= RESP;
          else                     wcnt  <= wcnt - 2'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit_c) begin
        ack     <= 1'b1;
        acc_cnt <= acc_cnt + 8'd1;
        if (!cwe_c) begin
          dout <= rdata_c;
        end else if (csel_c == 3'd7) begin
          wait_cfg <= cdin_c[1:0];
          holdoff  <= HW'(HOLDOFF);  // overrides the decrement above
        end else begin
          for (int i = 0; i < 6; i++) begin
            if (csel_c == 3'(i)) regs[i] <= cdin_c;
          end
        end
      end
    end
  end

endmodule

// File: doc/wb_slave_regfile.md
WB_SLAVE_REGFILE -- requirements
Module: wb_slave_regfile

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_0000, 8-aligned base address of the register window.
REQ-002 SHALL have parameter HOLDOFF, default 4, retry-window length in cycles after a control-register write.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 adr  input  32  Wishbone address from master.
REQ-006 din  input  8  Wishbone write data from master.
REQ-007 dout  output  8  Wishbone read data to master.
REQ-008 cyc  input  1  bus cycle valid.
REQ-009 stb  input  1  strobe; request = cyc & stb.
REQ-010 we  input  1  1 = write, 0 = read.
REQ-011 ack  output  1  normal termination, registered.
REQ-012 err  output  1  error termination, registered.
REQ-013 rty  output  1  retry termination, registered.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP; request sampled in IDLE at edge N.
REQ-015 Decode: hit when adr[31:3] == BASE[31:3]; adr[2:0] selects register R0..R7.
REQ-016 R0..R5: 8-bit read/write storage.
REQ-017 R6: read-only access counter, +1 on every ack'd access (read or write), wraps 255 -> 0; read returns pre-increment value.
REQ-018 R7: control, bits[1:0] = wait states W (0..3), bits[7:2] read 0, writes to bits[7:2] ignored.
REQ-019 Miss or write to R6 SHALL terminate with err, zero wait states, no state change.
REQ-020 Request sampled while holdoff counter > 0 SHALL terminate with rty, zero wait states, no state change.
REQ-021 Priority when sampled: rty over err over ack.
REQ-022 ack path: IDLE -> WAIT when W > 0, else -> RESP; WAIT counts W-1 further edges then -> RESP; ack high in the cycle after edge N+W.
REQ-023 W used for a transfer SHALL be the value latched at edge N; a write to R7 affects later transfers only.
REQ-024 Exactly one of ack/err/rty SHALL be high for exactly one cycle per terminated transfer; never two at once.
REQ-025 Write data and address SHALL be captured at edge N; register write and R6 increment commit at the edge that raises ack.
REQ-026 dout SHALL carry read data only while ack is high for a read; 8'h00 otherwise.
REQ-027 RESP -> IDLE unconditionally after one cycle; a request still present is resampled as a new transfer at the next edge.
REQ-028 cyc or stb low during WAIT SHALL abort: -> IDLE, no termination signal, no write, no counter increment.
REQ-029 An ack'd write to R7 SHALL load holdoff with HOLDOFF at the ack edge; holdoff decrements by 1 each following edge, saturating at 0.
REQ-030 New holdoff load SHALL override any concurrent decrement.

Reset
REQ-031 rst high SHALL immediately force: state IDLE; ack, err, rty = 0; dout = 8'h00; R0..R5 = 8'h00; R6 = 8'h00; R7 = 8'h00; holdoff = 0.
REQ-032 rst asserted mid-transfer SHALL drop any pending termination; no write commits.
REQ-033 First request SHALL be sampled at the first rising edge after rst deasserts.

Verification
REQ-034 Reset, write 8'hA5 to BASE+2 then read BASE+2 -> each ack one cycle after sampling edge, read returns 8'hA5, R6 reads 8'h02.
REQ-035 Write 8'h03 to BASE+7, wait 5 cycles, read BASE+0 -> ack rises 3 edges after sampling edge, dout 8'h00.
REQ-036 Write BASE+7, then request at next edge -> rty, one cycle, no increment; request after holdoff expiry -> ack.
REQ-037 Read adr 32'h0000_0100 (miss) and write BASE+6 -> err, one cycle each, R6 unchanged.
REQ-038 W=3, write 8'h5A to BASE+1, drop stb after 1 cycle -> no ack/err/rty, R1 stays 8'h00; assert rst during WAIT of another write -> outputs 0, registers reset.
REQ-039 256 ack'd reads of BASE+0 -> R6 wraps to 8'h00.
